// File: rtl/rrv_fetch.sv
// rrv_fetch: instruction fetch stage.
// It issues sequential reads to a synchronous instruction RAM and offers each
// returned word to decode. A one-entry skid buffer holds a returned word when
// decode stalls. Redirects flush everything in flight and restart at the target.
//
// Handshake: a word moves to decode on any cycle where inst_valid & dec_ready
// are both high. While inst_valid is high and dec_ready is low, inst/inst_pc
// stay stable until the transfer happens. The only exceptions are redirect and
// reset, which withdraw the offer.
module rrv_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_SIZE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        rsp_v;
  logic [31:0] rsp_pc;
  logic        skid_v;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        xfer;

  // State register for the boot/run/halt controller.
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next state. Boot lasts one cycle, and halt follows the halt_req level.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req)  state_nxt = HALT;
      HALT:    if (!halt_req) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Fetch issue and decode offer. A new read issues only when the held word
  // (skid or response) is leaving this cycle, or nothing is held at all.
  always_comb begin
    imem_rd_en = (state == RUN) && !rst && !halt_req && !redirect_valid &&
                 (!(skid_v || rsp_v) || dec_ready);
    imem_addr  = pc & ADDR_MASK;
    inst_valid = (skid_v || rsp_v) && !redirect_valid && !rst;
    xfer       = inst_valid && dec_ready;
    inst       = 32'd0;
    inst_pc    = 32'd0;
    if (inst_valid) begin
      inst    = skid_v ? skid_inst : imem_rd_data;
      inst_pc = skid_v ? skid_pc   : rsp_pc;
    end
    dbg_state  = state;
  end

  // PC, response tag, skid buffer, transfer counter and misalignment pulse.
  // Gating the fetch guarantees rsp_v and skid_v are never both set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      rsp_v        <= 1'b0;
      rsp_pc       <= 32'd0;
      skid_v       <= 1'b0;
      skid_inst    <= 32'd0;
      skid_pc      <= 32'd0;
      fetch_cnt    <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        rsp_v  <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        rsp_v <= imem_rd_en;
        if (imem_rd_en) begin
          pc     <= pc + 32'd4;
          rsp_pc <= pc;
        end
        if (skid_v && dec_ready) begin
          skid_v <= 1'b0;
        end
        if (rsp_v && !skid_v && !dec_ready) begin
          skid_v    <= 1'b1;
          skid_inst <= imem_rd_data;
          skid_pc   <= rsp_pc;
        end
        if (xfer) begin
          fetch_cnt <= fetch_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rrv_fetch.sv
// tb_rrv_fetch: self-checking bench for rrv_fetch.
// The RAM returns its own byte address as data. The reference model tracks the
// expected instruction stream as a queue of PCs. It restarts that queue on
// reset and on redirect, and checks every transfer, issue address, counter
// value and stall hold against it.
module tb_rrv_fetch;

  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        misalign_err;
  logic [31:0] fetch_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_issue;
  logic [31:0] exp_cnt;
  logic        exp_mis;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic        known = 1'b0;

  rrv_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dec_ready      (dec_ready),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM: word at byte address N holds N
  initial imem_rd_data = 32'd0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_data <= imem_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expected=finish observed=timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic restart(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(t + 32'(4 * i));
    exp_issue = t;
  endtask

  // scoreboard: check this cycle against the model, then advance the model
  task automatic mon();
    logic xfer;
    xfer = inst_valid && dec_ready;
    if (known) begin
      chk("fetch_cnt", fetch_cnt, exp_cnt);
      chk("misalign", 32'(misalign_err), 32'(exp_mis));
      if (rst) begin
        chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
      end
      if (redirect_valid) begin
        chk("redir_valid", 32'(inst_valid), 32'd0);
        chk("redir_rd_en", 32'(imem_rd_en), 32'd0);
      end
      if (halt_req) chk("halt_rd_en", 32'(imem_rd_en), 32'd0);
      if (imem_rd_en) chk("issue_addr", imem_addr, exp_issue & MASK);
      if (hold_v && !rst && !redirect_valid) begin
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_pc", inst_pc, hold_pc);
      end
      if (!inst_valid) begin
        chk("idle_inst", inst, 32'd0);
        chk("idle_pc", inst_pc, 32'd0);
      end
      if (xfer) begin
        chk("xfer_pc", inst_pc, exp_q[0]);
        chk("xfer_inst", inst, exp_q[0] & MASK);
      end
    end
    if (rst) begin
      restart(32'h0000_0000);
      exp_cnt = 32'd0;
      exp_mis = 1'b0;
      hold_v  = 1'b0;
      known   = 1'b1;
    end else if (known) begin
      if (xfer) begin
        void'(exp_q.pop_front());
        exp_q.push_back(exp_q[$] + 32'd4);
        exp_cnt = exp_cnt + 32'd1;
        n_xfer++;
      end
      hold_v  = inst_valid && !dec_ready && !redirect_valid;
      hold_pc = inst_pc;
      exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) restart({redirect_pc[31:2], 2'b00});
      else if (imem_rd_en) exp_issue = exp_issue + 32'd4;
    end
  endtask

  // driver tasks: inputs are set 1 after the rising edge, checks follow later
  task automatic settle();
    #1;
  endtask

  task automatic cyc();
    #1;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] p);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (inst_valid && inst_pc == p) return;
      cyc();
    end
    chk("run_to_timeout", inst_pc, p);
  endtask

  initial begin
    logic [31:0] p;
    int          cnt0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    halt_req = 1'b0; dec_ready = 1'b0;
    @(posedge clk); #1;
    cyc();
    cyc();

    // reset state
    settle();
    chk("reset_rd_en", 32'(imem_rd_en), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_cnt", fetch_cnt, 32'd0);
    chk("reset_mis", 32'(misalign_err), 32'd0);
    cyc();

    // streaming
    rst = 1'b0; dec_ready = 1'b1;
    settle();
    chk("boot_rd_en", 32'(imem_rd_en), 32'd0);
    chk("boot_state", 32'(dbg_state), 32'd0);
    cyc();
    settle();
    chk("first_rd_en", 32'(imem_rd_en), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    cyc();
    settle();
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc", inst_pc, 32'd0);
    repeat (10) cyc();
    settle();
    chk("stream_cnt", fetch_cnt, 32'd10);
    cyc();

    // backpressure at 0x8
    do_reset();
    dec_ready = 1'b1;
    run_to(32'h8);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_rd_en", 32'(imem_rd_en), 32'd0);
      cyc();
    end
    dec_ready = 1'b1;
    settle();
    chk("bp_release_pc", inst_pc, 32'h8);
    cyc();
    settle();
    chk("bp_next_valid", 32'(inst_valid), 32'd1);
    chk("bp_next_pc", inst_pc, 32'hC);
    cyc();
    settle();
    chk("bp_next2_valid", 32'(inst_valid), 32'd1);
    chk("bp_next2_pc", inst_pc, 32'h10);
    cyc();

    // redirect while skid holds 0xC
    do_reset();
    dec_ready = 1'b1;
    run_to(32'hC);
    dec_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1;
    settle();
    chk("redir_valid0", 32'(inst_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    settle();
    chk("redir_rd_en1", 32'(imem_rd_en), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    cyc();
    settle();
    chk("redir_valid2", 32'(inst_valid), 32'd1);
    chk("redir_pc", inst_pc, 32'h100);
    cyc();

    // misaligned redirect with address wrap
    redirect_valid = 1'b1; redirect_pc = 32'h0001_0006;
    cyc();
    redirect_valid = 1'b0;
    settle();
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_addr", imem_addr, 32'h4);
    cyc();
    settle();
    chk("mis_clear", 32'(misalign_err), 32'd0);
    chk("mis_pc", inst_pc, 32'h0001_0004);
    chk("mis_inst", inst, 32'h4);
    cyc();

    // halt for 5 cycles
    repeat (3) cyc();
    halt_req = 1'b1;
    settle();
    chk("halt_drain_valid", 32'(inst_valid), 32'd1);
    p = inst_pc;
    cyc();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("halt_idle_valid", 32'(inst_valid), 32'd0);
      cyc();
    end
    halt_req = 1'b0;
    settle();
    chk("halt_exit_rd_en", 32'(imem_rd_en), 32'd0);
    cyc();
    settle();
    chk("resume_rd_en", 32'(imem_rd_en), 32'd1);
    chk("resume_addr", imem_addr, (p + 32'd4) & MASK);
    cyc();

    // reset mid-stream with skid full
    dec_ready = 1'b0;
    cyc();
    settle();
    chk("skid_full_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; dec_ready = 1'b1;
    settle();
    chk("mrst_cnt", fetch_cnt, 32'd0);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'd0);
    cyc();
    settle();
    chk("mrst_rd_en", 32'(imem_rd_en), 32'd1);
    chk("mrst_addr", imem_addr, 32'h0);
    cyc();

    // pc wrap across 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    repeat (6) cyc();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    // drain and confirm forward progress
    rst = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; dec_ready = 1'b1;
    cnt0 = n_xfer;
    repeat (8) cyc();
    chk("progress", 32'(n_xfer > cnt0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
